// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Byte-stream program loader that drives the write side of the instruction
//   memory. It accepts a frame on a valid/ready byte stream:
//     LEN_LO, LEN_HI (word count N, little-endian), 4*N payload bytes, CHK
//   Payload bytes are assembled LSB-first into 32-bit words. Each word is
//   written to consecutive word addresses starting at 0. CHK is the XOR of
//   all payload bytes. The CPU is held in reset until a frame loads cleanly.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   1-cycle pulse, arms the loader in IDLE/DONE/ERROR
//   rx_valid   in   byte available on rx_data
//   rx_data    in   stream byte
//   rx_ready   out  loader accepts a byte (transfer = rx_valid & rx_ready)
//   im_we      out  instruction memory write strobe, 1 cycle per word
//   im_addr    out  byte address of the written word (word_idx << 2)
//   im_wdata   out  assembled word {b3,b2,b1,b0}
//   cpu_hold   out  1 = keep the CPU in reset
//   load_done  out  frame loaded with a good checksum (sticky until start)
//   load_err   out  frame rejected (sticky until start)
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int AW = $clog2(DEPTH_WORDS) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_CYC);
  localparam logic [15:0]   DEPTH_V   = 16'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  // Running checksum update over one payload byte.
  function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t          state_r;
  state_t          state_next_s;
  logic            rx_ready_r;
  logic            im_we_r;
  logic [31:0]     im_addr_r;
  logic [31:0]     im_wdata_r;
  logic            cpu_hold_r;
  logic            load_done_r;
  logic            load_err_r;
  logic [AW-1:0]   word_idx_r;
  logic [1:0]      byte_cnt_r;
  logic [7:0]      chk_r;
  logic [TW-1:0]   timer_r;
  logic [7:0]      len_lo_r;
  logic [15:0]     n_r;
  logic [23:0]     asm_r;

  logic            active_s;
  logic            timeout_s;
  logic            acc_s;
  logic            start_acc_s;
  logic            last_word_s;
  logic            word_done_s;
  logic [15:0]     len_s;

  assign active_s    = (state_r == LEN_LO) || (state_r == LEN_HI) ||
                       (state_r == DATA)   || (state_r == CHECK);
  assign timeout_s   = active_s && (timer_r == TIMEOUT_V);
  // A timeout wins over a byte arriving in the same cycle.
  assign acc_s       = rx_valid && rx_ready_r && !timeout_s;
  assign start_acc_s = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERROR));
  assign len_s       = {rx_data, len_lo_r};
  assign last_word_s = ((16'(word_idx_r) + 16'd1) == n_r);
  assign word_done_s = acc_s && (state_r == DATA) && (byte_cnt_r == 2'd3);

  // Next-state logic for the frame parser.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE, ERROR: begin
        if (start) state_next_s = LEN_LO;
        else       state_next_s = state_r;
      end
      LEN_LO: begin
        if (timeout_s)  state_next_s = ERROR;
        else if (acc_s) state_next_s = LEN_HI;
        else            state_next_s = state_r;
      end
      LEN_HI: begin
        if (timeout_s) begin
          state_next_s = ERROR;
        end else if (acc_s) begin
          if (len_s == 16'd0)       state_next_s = CHECK;
          else if (len_s > DEPTH_V) state_next_s = ERROR;
          else                      state_next_s = DATA;
        end else begin
          state_next_s = state_r;
        end
      end
      DATA: begin
        if (timeout_s)                       state_next_s = ERROR;
        else if (word_done_s && last_word_s) state_next_s = CHECK;
        else                                 state_next_s = state_r;
      end
      CHECK: begin
        if (timeout_s) begin
          state_next_s = ERROR;
        end else if (acc_s) begin
          if (rx_data == chk_r) state_next_s = DONE;
          else                  state_next_s = ERROR;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Status outputs registered from the next state so they track the state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready_r  <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      rx_ready_r  <= (state_next_s == LEN_LO) || (state_next_s == LEN_HI) ||
                     (state_next_s == DATA)   || (state_next_s == CHECK);
      load_done_r <= (state_next_s == DONE);
      load_err_r  <= (state_next_s == ERROR);
    end
  end

  // CPU hold: released one cycle after DONE is reached, re-asserted as start is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cpu_hold_r <= 1'b1;
    else          cpu_hold_r <= (state_r != DONE) || start;
  end

  // Frame datapath: length capture, lane assembly, checksum and idle timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx_r <= '0;
      byte_cnt_r <= 2'd0;
      chk_r      <= 8'd0;
      timer_r    <= '0;
      len_lo_r   <= 8'd0;
      n_r        <= 16'd0;
      asm_r      <= 24'd0;
    end else if (start_acc_s) begin
      word_idx_r <= '0;
      byte_cnt_r <= 2'd0;
      chk_r      <= 8'd0;
      timer_r    <= '0;
    end else begin
      if (active_s) begin
        if (rx_valid)              timer_r <= '0;
        else if (!timeout_s)       timer_r <= timer_r + TW'(1);
        else                       timer_r <= timer_r;
      end else begin
        timer_r <= '0;
      end
      if (acc_s && (state_r == LEN_LO)) len_lo_r <= rx_data;
      if (acc_s && (state_r == LEN_HI)) n_r      <= len_s;
      if (acc_s && (state_r == DATA)) begin
        chk_r <= chk_next(chk_r, rx_data);
        case (byte_cnt_r)
          2'd0:    asm_r[7:0]   <= rx_data;
          2'd1:    asm_r[15:8]  <= rx_data;
          2'd2:    asm_r[23:16] <= rx_data;
          default: asm_r        <= asm_r;
        endcase
        if (byte_cnt_r == 2'd3) begin
          byte_cnt_r <= 2'd0;
          word_idx_r <= word_idx_r + AW'(1);
        end else begin
          byte_cnt_r <= byte_cnt_r + 2'd1;
        end
      end
    end
  end

  // Instruction memory write port; address and data hold between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      im_we_r    <= 1'b0;
      im_addr_r  <= 32'd0;
      im_wdata_r <= 32'd0;
    end else begin
      im_we_r <= word_done_s;
      if (word_done_s) begin
        im_addr_r  <= 32'({word_idx_r, 2'b00});
        im_wdata_r <= {rx_data, asm_r};
      end
    end
  end

  assign rx_ready  = rx_ready_r;
  assign im_we     = im_we_r;
  assign im_addr   = im_addr_r;
  assign im_wdata  = im_wdata_r;
  assign cpu_hold  = cpu_hold_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed self-checking bench for imem_loader. Inputs are driven 1 time
//   unit after the rising edge; outputs are sampled at the same point, and
//   write strobes are captured on the falling edge.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int TCYC = 40;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int checks;
  int errors;
  int cyc;
  int we_cnt;
  logic [31:0] we_addr [0:7];
  logic [31:0] we_data [0:7];
  int          we_cyc  [0:7];
  logic [7:0]  fr [0:15];
  int          f0;

  imem_loader #(.DEPTH_WORDS(256), .TIMEOUT_CYC(TCYC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe with its cycle stamp.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (we_cnt < 8) begin
        we_addr[we_cnt] = im_addr;
        we_data[we_cnt] = im_wdata;
        we_cyc[we_cnt]  = cyc;
      end
      we_cnt = we_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Present one byte and hold it until it is taken (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_valid = 1'b1;
    rx_data  = b;
    k = 0;
    while (!rx_ready && k < 20) begin
      tick(1);
      k++;
    end
    if (!rx_ready) check_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
    tick(1);
  endtask

  // Send fr[0..n-1] back-to-back, leaving rx_valid low afterwards.
  task automatic send_fr(input int n);
    for (int i = 0; i < n; i++) send_byte(fr[i]);
    rx_valid = 1'b0;
  endtask

  task automatic set_frame1(input logic [7:0] chk);
    fr[0]  = 8'h02; fr[1]  = 8'h00;
    fr[2]  = 8'h23; fr[3]  = 8'h20; fr[4] = 8'h00; fr[5] = 8'h04;
    fr[6]  = 8'h23; fr[7]  = 8'h22; fr[8] = 8'h00; fr[9] = 8'h04;
    fr[10] = chk;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
    check_eq({tag, "_im_we"},     32'(im_we),     32'd0);
    check_eq({tag, "_im_addr"},   im_addr,        32'd0);
    check_eq({tag, "_im_wdata"},  im_wdata,       32'd0);
    check_eq({tag, "_cpu_hold"},  32'(cpu_hold),  32'd1);
    check_eq({tag, "_load_done"}, 32'(load_done), 32'd0);
    check_eq({tag, "_load_err"},  32'(load_err),  32'd0);
  endtask

  // Frame 1 from a fresh start, with timing of strobes and sustained rate.
  task automatic run_frame1(input string tag);
    we_cnt = 0;
    pulse_start();
    check_eq({tag, "_ready_after_start"}, 32'(rx_ready), 32'd1);
    check_eq({tag, "_hold_after_start"},  32'(cpu_hold), 32'd1);
    set_frame1(8'h02);
    f0 = cyc;
    send_fr(11);
    check_eq({tag, "_frame_cycles"}, 32'(cyc - f0), 32'd11);
    tick(2);
    check_eq({tag, "_we_cnt"},   32'(we_cnt),    32'd2);
    check_eq({tag, "_addr0"},    we_addr[0],     32'h0000_0000);
    check_eq({tag, "_data0"},    we_data[0],     32'h0400_2023);
    check_eq({tag, "_addr1"},    we_addr[1],     32'h0000_0004);
    check_eq({tag, "_data1"},    we_data[1],     32'h0400_2223);
    check_eq({tag, "_we0_lat"},  32'(we_cyc[0] - f0), 32'd6);
    check_eq({tag, "_we1_lat"},  32'(we_cyc[1] - f0), 32'd10);
    check_eq({tag, "_done"},     32'(load_done), 32'd1);
    check_eq({tag, "_err"},      32'(load_err),  32'd0);
    check_eq({tag, "_hold"},     32'(cpu_hold),  32'd0);
    check_eq({tag, "_ready"},    32'(rx_ready),  32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    we_cnt   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(3);
    check_reset_vals("rst");
    reset_n = 1'b1;
    tick(2);

    // Bytes offered in IDLE are not taken.
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    tick(3);
    check_eq("idle_ready", 32'(rx_ready), 32'd0);
    check_eq("idle_hold",  32'(cpu_hold), 32'd1);
    rx_valid = 1'b0;
    tick(1);

    // 1: good two-word frame.
    run_frame1("t1");

    // 2: same frame with a bad checksum.
    we_cnt = 0;
    pulse_start();
    check_eq("t2_hold_rise", 32'(cpu_hold),  32'd1);
    check_eq("t2_done_clr",  32'(load_done), 32'd0);
    set_frame1(8'h03);
    send_fr(11);
    tick(2);
    check_eq("t2_we_cnt", 32'(we_cnt),    32'd2);
    check_eq("t2_data1",  we_data[1],     32'h0400_2223);
    check_eq("t2_err",    32'(load_err),  32'd1);
    check_eq("t2_done",   32'(load_done), 32'd0);
    check_eq("t2_hold",   32'(cpu_hold),  32'd1);

    // 3: N=257 exceeds capacity.
    we_cnt = 0;
    pulse_start();
    check_eq("t3_err_clr", 32'(load_err), 32'd0);
    fr[0] = 8'h01; fr[1] = 8'h01;
    send_fr(2);
    check_eq("t3_ready", 32'(rx_ready), 32'd0);
    check_eq("t3_err",   32'(load_err), 32'd1);
    tick(3);
    check_eq("t3_we_cnt", 32'(we_cnt), 32'd0);

    // 4: empty frame.
    we_cnt = 0;
    pulse_start();
    fr[0] = 8'h00; fr[1] = 8'h00; fr[2] = 8'h00;
    send_fr(3);
    tick(2);
    check_eq("t4_done",   32'(load_done), 32'd1);
    check_eq("t4_hold",   32'(cpu_hold),  32'd0);
    check_eq("t4_we_cnt", 32'(we_cnt),    32'd0);

    // 5: idle timeout inside a partial word.
    we_cnt = 0;
    pulse_start();
    fr[0] = 8'h01; fr[1] = 8'h00; fr[2] = 8'hAA; fr[3] = 8'hBB; fr[4] = 8'hCC;
    send_fr(5);
    tick(TCYC);
    check_eq("t5_err_early", 32'(load_err), 32'd0);
    tick(1);
    check_eq("t5_err",    32'(load_err),  32'd1);
    check_eq("t5_done",   32'(load_done), 32'd0);
    check_eq("t5_hold",   32'(cpu_hold),  32'd1);
    tick(3);
    check_eq("t5_we_cnt", 32'(we_cnt),    32'd0);

    // 6: reset mid-frame, then a clean reload.
    we_cnt = 0;
    pulse_start();
    set_frame1(8'h02);
    send_fr(8);
    reset_n  = 1'b0;
    #1;
    check_reset_vals("t6");
    tick(3);
    check_eq("t6_we_cnt", 32'(we_cnt), 32'd1);
    reset_n = 1'b1;
    tick(1);
    run_frame1("t6r");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
